// File: rtl/disp_scanout.sv
// disp_scanout: framebuffer scan-out reader.
// Fetches the front buffer from SDRAM through one read-only arbiter port into a prefetch
// FIFO and hands pixels to the LCD timing block on demand. Owns the double-buffer flip:
// a swap request is latched and applied at the next frame_start.
//
// Ports:
//   clk_sys_i, reset_i          system clock, asynchronous active-high reset
//   frame_start_i               one-cycle pulse at start of vblank (flip + restart fetch)
//   pix_req_i                   consume one pixel; pix_data_o/pix_valid_o answer next cycle
//   pix_data_o, pix_valid_o     pixel and "real data" flag (0 = underflow)
//   swap_i, stat_o              renderer swap request, currently displayed buffer
//   mem_addr_o/req_o/wr_o       arbiter read request (wr tied 0), held until mem_ack_i
//   mem_ack_i, mem_valid_i,
//   mem_data_i                  request accepted, in-order read return
//
// Optional feature (macro DISP_SCANOUT_STATS_EN): adds underflow_cnt_o (saturating) and
// frame_cnt_o (wrapping) and shows underflowed pixels as red instead of black.
module disp_scanout #(
  parameter int unsigned   AN   = 24,
  parameter int unsigned   DN   = 16,
  parameter logic [AN-1:0] BASE = '0,
  parameter logic [AN-1:0] SWAP = AN'(32'h100000),
  parameter int unsigned   W    = 800,
  parameter int unsigned   H    = 480,
  parameter int unsigned   FN   = 32
) (
  input  logic          clk_sys_i,
  input  logic          reset_i,
  input  logic          frame_start_i,
  input  logic          pix_req_i,
  output logic [DN-1:0] pix_data_o,
  output logic          pix_valid_o,
  input  logic          swap_i,
  output logic          stat_o,
  output logic [AN-1:0] mem_addr_o,
  output logic          mem_req_o,
  output logic          mem_wr_o,
  input  logic          mem_ack_i,
  input  logic          mem_valid_i,
  input  logic [DN-1:0] mem_data_i
`ifdef DISP_SCANOUT_STATS_EN
  ,
  output logic [15:0]   underflow_cnt_o,
  output logic [15:0]   frame_cnt_o
`endif
);

  localparam int unsigned NPix = W * H;
  localparam int unsigned PW   = $clog2(NPix + 1);
  localparam int unsigned CW   = $clog2(FN + 1);
  localparam int unsigned CW1  = CW + 1;
  localparam int unsigned AW   = $clog2(FN);

  localparam logic [PW-1:0]  NPixW   = PW'(NPix);
  localparam logic [PW-1:0]  LastIdx = PW'(NPix - 1);
  localparam logic [CW:0]    FnW     = CW1'(FN);
`ifdef DISP_SCANOUT_STATS_EN
  localparam logic [DN-1:0]  UfData  = DN'(16'hf800);
`else
  localparam logic [DN-1:0]  UfData  = '0;
`endif

  typedef enum logic [1:0] {StIdle, StFetch, StDone} state_e;

  state_e          state_q, state_d;
  logic            stat_q, stat_d;
  logic            swap_pend_q, swap_pend_d;
  logic [AN-1:0]   addr_q, addr_d;
  logic [PW-1:0]   issued_q, issued_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DN-1:0]   pix_data_q, pix_data_d;
  logic            pix_valid_q, pix_valid_d;
  logic [DN-1:0]   fifo_q [FN];

  logic            ack, pop, empty, fifo_we;
  logic [CW:0]     occ;

  // Occupancy includes words still in flight so the FIFO can never overflow.
  assign occ       = {1'b0, count_q} + {1'b0, inflight_q};
  assign mem_req_o = (state_q == StFetch) && (occ < FnW) && (issued_q < NPixW);
  assign ack       = mem_req_o & mem_ack_i;
  assign empty     = (count_q == '0);
  assign pop       = pix_req_i & ~empty;
  // Returns belonging to the previous frame are dropped; a flush also drops this cycle's.
  assign fifo_we   = mem_valid_i & (discard_q == '0) & ~frame_start_i;

  assign mem_addr_o  = addr_q;
  assign mem_wr_o    = 1'b0;
  assign stat_o      = stat_q;
  assign pix_data_o  = pix_data_q;
  assign pix_valid_o = pix_valid_q;

  always_comb begin
    state_d     = state_q;
    stat_d      = stat_q;
    swap_pend_d = swap_pend_q;
    addr_d      = addr_q;
    issued_d    = issued_q;
    inflight_d  = inflight_q + CW'(ack) - CW'(mem_valid_i);
    count_d     = count_q + CW'(fifo_we) - CW'(pop);
    discard_d   = discard_q;
    wr_ptr_d    = fifo_we ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    pix_valid_d = pop;
    pix_data_d  = pix_data_q;

    if (pop) begin
      pix_data_d = fifo_q[rd_ptr_q];
    end else if (pix_req_i) begin
      pix_data_d = UfData;
    end

    if (mem_valid_i && (discard_q != '0)) begin
      discard_d = discard_q - CW'(1);
    end

    if (ack) begin
      addr_d   = addr_q + AN'(1);
      issued_d = issued_q + PW'(1);
      if (issued_q == LastIdx) begin
        state_d = StDone;
      end
    end

    if (swap_i) begin
      swap_pend_d = 1'b1;
    end

    if (frame_start_i) begin
      stat_d      = stat_q ^ (swap_pend_q | swap_i);
      swap_pend_d = 1'b0;
      addr_d      = BASE + (stat_d ? SWAP : '0);
      issued_d    = '0;
      count_d     = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      // Everything still outstanding (including an ack this cycle) is old-frame data.
      discard_d   = inflight_d;
      state_d     = StFetch;
    end
  end

  always_ff @(posedge clk_sys_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      stat_q      <= 1'b0;
      swap_pend_q <= 1'b0;
      addr_q      <= BASE;
      issued_q    <= '0;
      inflight_q  <= '0;
      count_q     <= '0;
      discard_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stat_q      <= stat_d;
      swap_pend_q <= swap_pend_d;
      addr_q      <= addr_d;
      issued_q    <= issued_d;
      inflight_q  <= inflight_d;
      count_q     <= count_d;
      discard_q   <= discard_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pix_data_q  <= pix_data_d;
      pix_valid_q <= pix_valid_d;
    end
  end

  // Storage needs no reset: count_q gates every read.
  always_ff @(posedge clk_sys_i) begin
    if (fifo_we) begin
      fifo_q[wr_ptr_q] <= mem_data_i;
    end
  end

`ifdef DISP_SCANOUT_STATS_EN
  logic [15:0] uf_cnt_q, uf_cnt_d;
  logic [15:0] fr_cnt_q, fr_cnt_d;

  always_comb begin
    uf_cnt_d = uf_cnt_q;
    fr_cnt_d = fr_cnt_q;
    if (pix_req_i && empty && (uf_cnt_q != 16'hffff)) begin
      uf_cnt_d = uf_cnt_q + 16'd1;
    end
    if (frame_start_i) begin
      fr_cnt_d = fr_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_sys_i or posedge reset_i) begin
    if (reset_i) begin
      uf_cnt_q <= '0;
      fr_cnt_q <= '0;
    end else begin
      uf_cnt_q <= uf_cnt_d;
      fr_cnt_q <= fr_cnt_d;
    end
  end

  assign underflow_cnt_o = uf_cnt_q;
  assign frame_cnt_o     = fr_cnt_q;
`endif

endmodule

// File: tb/tb_disp_scanout.sv
// Bench for disp_scanout with a small frame (64x4), a 3-cycle in-order memory model and a
// pixel scoreboard filled at each frame_start with the words the new front buffer holds.
module tb_disp_scanout;

  localparam int unsigned   AN   = 24;
  localparam int unsigned   DN   = 16;
  localparam int unsigned   W    = 64;
  localparam int unsigned   H    = 4;
  localparam int unsigned   FN   = 32;
  localparam int unsigned   NPIX = W * H;
  localparam logic [AN-1:0] BASE = 24'h000000;
  localparam logic [AN-1:0] SWAP = 24'h100000;
`ifdef DISP_SCANOUT_STATS_EN
  localparam logic [DN-1:0] UF   = 16'hf800;
`else
  localparam logic [DN-1:0] UF   = 16'h0000;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_start, pix_req, swap;
  logic [DN-1:0] pix_data;
  logic          pix_valid, stat;
  logic [AN-1:0] mem_addr;
  logic          mem_req, mem_wr, mem_ack, mem_valid;
  logic [DN-1:0] mem_data;
`ifdef DISP_SCANOUT_STATS_EN
  logic [15:0]   underflow_cnt, frame_cnt;
`endif

  always #5 clk = ~clk;

  disp_scanout #(
    .AN(AN), .DN(DN), .BASE(BASE), .SWAP(SWAP), .W(W), .H(H), .FN(FN)
  ) dut (
    .clk_sys_i     (clk),
    .reset_i       (reset),
    .frame_start_i (frame_start),
    .pix_req_i     (pix_req),
    .pix_data_o    (pix_data),
    .pix_valid_o   (pix_valid),
    .swap_i        (swap),
    .stat_o        (stat),
    .mem_addr_o    (mem_addr),
    .mem_req_o     (mem_req),
    .mem_wr_o      (mem_wr),
    .mem_ack_i     (mem_ack),
    .mem_valid_i   (mem_valid),
    .mem_data_i    (mem_data)
`ifdef DISP_SCANOUT_STATS_EN
    ,
    .underflow_cnt_o (underflow_cnt),
    .frame_cnt_o     (frame_cnt)
`endif
  );

  // Memory content: low address bits, with bit 15 marking buffer 1.
  function automatic logic [DN-1:0] pat(input logic [AN-1:0] a);
    return {a[20], a[14:0]};
  endfunction

  // ---- memory model: accepts when ack_en, returns in order 3 cycles after ack ----
  logic          ack_en, hold_ret;
  logic [AN-1:0] pend_addr [$];
  int unsigned   pend_due  [$];
  int unsigned   cyc;
  int unsigned   ack_cnt = 0;

  assign mem_ack = mem_req & ack_en;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_addr.delete();
      pend_due.delete();
      mem_valid <= 1'b0;
      mem_data  <= '0;
      cyc       <= 0;
    end else begin
      cyc       <= cyc + 1;
      mem_valid <= 1'b0;
      if (pend_addr.size() > 0 && !hold_ret && pend_due[0] <= cyc) begin
        mem_valid <= 1'b1;
        mem_data  <= pat(pend_addr[0]);
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      if (mem_req && mem_ack) begin
        pend_addr.push_back(mem_addr);
        pend_due.push_back(cyc + 2);
        ack_cnt <= ack_cnt + 1;
      end
    end
  end

  // ---- scoreboard and checking ----
  logic [DN-1:0] sb [$];
  int n_vec = 0;
  int n_err = 0;
  int uf_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [AN-1:0] base);
    sb.delete();
    for (int i = 0; i < NPIX; i++) sb.push_back(pat(base + AN'(i)));
  endtask

  // One clock; afterwards check the pixel answer to this cycle's pix_req.
  task automatic step();
    logic req_was;
    req_was = pix_req;
    @(posedge clk);
    #1;
    if (!req_was) begin
      check("valid_without_req", pix_valid, 1'b0);
    end else if (pix_valid === 1'b1) begin
      if (sb.size() == 0) check("pixel_beyond_frame", sb.size(), 1);
      else check("pix_data", pix_data, sb.pop_front());
    end else begin
      uf_seen++;
      check("underflow_data", pix_data, UF);
    end
  endtask

  task automatic fs();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 2000;
    while (sb.size() > 0 && budget > 0) begin
      pix_req = 1'b1;
      step();
      pix_req = 1'b0;
      step();
      budget--;
    end
    check("frame_drained_left", sb.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned a0;
    int          u0;
    logic [15:0] ufc0;

    reset = 1'b1; frame_start = 1'b0; pix_req = 1'b0; swap = 1'b0;
    ack_en = 1'b1; hold_ret = 1'b0; ufc0 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stat", stat, 1'b0);
    check("rst_pix_valid", pix_valid, 1'b0);
    check("rst_pix_data", pix_data, '0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_addr", mem_addr, BASE);
    check("rst_mem_wr", mem_wr, 1'b0);
`ifdef DISP_SCANOUT_STATS_EN
    check("rst_uf_cnt", underflow_cnt, 16'd0);
    check("rst_frame_cnt", frame_cnt, 16'd0);
`endif
    reset = 1'b0;
    step();
    check("idle_mem_req", mem_req, 1'b0);

    // Frame 1: prefetch stops at FIFO depth, then full frame at half rate, no underflow.
    a0 = ack_cnt;
    push_frame(BASE);
    fs();
    check("f1_stat", stat, 1'b0);
    check("f1_mem_req", mem_req, 1'b1);
    check("f1_first_addr", mem_addr, BASE);
    repeat (40) step();
    check("f1_prefetch_words", ack_cnt - a0, FN);
    check("f1_req_when_full", mem_req, 1'b0);
    pix_req = 1'b1;
    step();
    pix_req = 1'b0;
    check("f1_req_after_pop", mem_req, 1'b1);
    u0 = uf_seen;
    drain();
    check("f1_underflows", uf_seen - u0, 0);
    check("f1_total_reqs", ack_cnt - a0, NPIX);
    check("f1_done_mem_req", mem_req, 1'b0);
    pix_req = 1'b1;
    step();
    pix_req = 1'b0;
    check("f1_past_end_valid", pix_valid, 1'b0);
`ifdef DISP_SCANOUT_STATS_EN
    check("f1_frame_cnt", frame_cnt, 16'd1);
    check("f1_uf_cnt", underflow_cnt, 16'd1);
`endif

    // Frame 2: two swap pulses mid-frame; stat must wait for the next frame_start.
    push_frame(BASE);
    fs();
    check("f2_stat", stat, 1'b0);
    check("f2_first_addr", mem_addr, BASE);
    repeat (5) step();
    swap = 1'b1;
    step();
    swap = 1'b0;
    check("f2_stat_after_swap1", stat, 1'b0);
    repeat (10) step();
    swap = 1'b1;
    step();
    swap = 1'b0;
    check("f2_stat_after_swap2", stat, 1'b0);
    repeat (60) step();

    // Frame 3: flipped buffer, memory stalled for 40 requests.
    ack_en = 1'b0;
    push_frame(BASE + SWAP);
    fs();
    check("f3_stat", stat, 1'b1);
    check("f3_first_addr", mem_addr, BASE + SWAP);
    check("f3_mem_req", mem_req, 1'b1);
`ifdef DISP_SCANOUT_STATS_EN
    ufc0 = underflow_cnt;
`endif
    u0 = uf_seen;
    pix_req = 1'b1;
    repeat (40) step();
    pix_req = 1'b0;
    step();
    check("stall_underflows", uf_seen - u0, 40);
    check("stall_addr_held", mem_addr, BASE + SWAP);
`ifdef DISP_SCANOUT_STATS_EN
    check("stall_uf_cnt_delta", 16'(underflow_cnt - ufc0), 16'd40);
`endif
    ack_en = 1'b1;
    repeat (15) step();
    drain();
`ifdef DISP_SCANOUT_STATS_EN
    check("f3_frame_cnt", frame_cnt, 16'd3);
`endif

    // Frame 4: no new swap, so stat stays; leave 5 reads outstanding, then swap back.
    hold_ret = 1'b1;
    a0 = ack_cnt;
    fs();
    check("f4_single_toggle", stat, 1'b1);
    repeat (5) step();
    ack_en = 1'b0;
    check("f4_outstanding", ack_cnt - a0, 5);
    swap = 1'b1;
    step();
    swap = 1'b0;

    // Frame 5: the 5 stale returns must be dropped; first pixel is word 0 of buffer 0.
    push_frame(BASE);
    ack_en = 1'b1;
    hold_ret = 1'b0;
    fs();
    check("f5_stat", stat, 1'b0);
    check("f5_first_addr", mem_addr, BASE);
    repeat (40) step();
    drain();

    // Reset in the middle of a fetch.
    swap = 1'b1;
    push_frame(BASE + SWAP);
    fs();
    swap = 1'b0;
    check("f6_stat", stat, 1'b1);
    repeat (6) begin
      pix_req = 1'b1;
      step();
      pix_req = 1'b0;
      step();
    end
    check("f6_mem_req_active", mem_req, 1'b1);
    reset = 1'b1;
    #1;
    check("rst_mid_mem_req", mem_req, 1'b0);
    check("rst_mid_stat", stat, 1'b0);
    check("rst_mid_pix_valid", pix_valid, 1'b0);
    check("rst_mid_mem_addr", mem_addr, BASE);
    sb.delete();
    step();
    reset = 1'b0;
    step();
    check("rst_mid_idle_req", mem_req, 1'b0);
    pix_req = 1'b1;
    step();
    pix_req = 1'b0;
    check("rst_mid_fifo_empty", pix_valid, 1'b0);
`ifdef DISP_SCANOUT_STATS_EN
    check("rst_mid_frame_cnt", frame_cnt, 16'd0);
    check("rst_mid_uf_cnt", underflow_cnt, 16'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
